// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan multiplexer: mode encodings and the width helper.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Never returns 0, so a 1-entry range still gets a usable 1-bit vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel bus, select controls and registered outputs of the scan multiplexer.
interface scan_mux_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
);
  import scan_mux_pkg::*;

  localparam int unsigned SW = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] din;
  logic [SW-1:0]             sel;
  logic                      mode;
  logic                      en;
  logic [WIDTH-1:0]          dout;
  logic [CHANNELS-1:0]       strobe;
  logic [SW-1:0]             idx;
  logic                      tick;

  modport master (
    output din, sel, mode, en,
    input  dout, strobe, idx, tick
  );

  modport slave (
    input  din, sel, mode, en,
    output dout, strobe, idx, tick
  );

endinterface

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 while running, pulses tick on each wrap.
module scan_prescaler
  import scan_mux_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic step,
  output logic tick
);

  localparam int unsigned      PW   = clog2(DIV);
  localparam logic [PW-1:0]    Last = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;

  // step flags the edge on which the count wraps, so the index can advance on that same edge.
  assign step = run && (pcnt_q == Last);

  always_comb begin
    pcnt_d = '0;
    tick_d = 1'b0;
    if (run) begin
      if (step) begin
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 channel multiplexer with manual select or prescaled round-robin scan.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV      = 50000
) (
  input  logic        clk,
  input  logic        rst,
  scan_mux_if.slave   bus
);

  localparam int unsigned   SW      = clog2(CHANNELS);
  localparam int unsigned   SelSpan = 2 ** SW;
  localparam logic [SW-1:0] LastIdx = SW'(CHANNELS - 1);

  logic run, step, tick;

  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [SelSpan-1:0]  sel_ok;

  logic [SW-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic [CHANNELS-1:0] strobe_q, strobe_d;

  assign run = bus.en && (bus.mode == MODE_SCAN);

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .step (step),
    .tick (tick)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = bus.din[k*WIDTH +: WIDTH];
  end

  // Select codes at or above CHANNELS are ignored; the table keeps the check width-safe.
  for (genvar k = 0; k < SelSpan; k++) begin : g_sel_ok
    assign sel_ok[k] = (k < CHANNELS);
  end

  always_comb begin
    idx_d = idx_q;
    if (!bus.en) begin
      idx_d = idx_q;
    end else if (bus.mode == MODE_MANUAL) begin
      if (sel_ok[bus.sel]) begin
        idx_d = bus.sel;
      end
    end else if (step) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    dout_d   = chan[idx_d];
    strobe_d = bus.en ? (CHANNELS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      dout_q   <= '0;
      strobe_q <= '0;
    end else begin
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.idx    = idx_q;
  assign bus.dout   = dout_q;
  assign bus.strobe = strobe_q;
  assign bus.tick   = tick;

endmodule
